// File: rtl/aegnn_pkg.sv
// Shared constants and types for the AEGNN graph pipeline blocks.
// Feature width, channel count and grid geometry must agree across all stages.
package aegnn;

  localparam int F_WIDTH  = 8;
  localparam int L4_OUT_C = 32;
  localparam int GRID_NUM = 64;

  typedef logic [$clog2(GRID_NUM)-1:0] grid_idx_t;

endpackage

// File: rtl/max_pool_mem.sv
// 1R1W synchronous-read RAM holding one running-max vector per grid cell.
// No reset on contents; stale data is masked by the owner's valid bits.
module max_pool_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/max_pool_dx.sv
// Per-grid running max pooling; emits the per-channel max increase (dx) to the
// linear block through a start/done handshake whenever any channel grows.
module max_pool_dx
  import aegnn::F_WIDTH, aegnn::grid_idx_t;
#(
  parameter int L4_OUT_C = aegnn::L4_OUT_C,
  parameter int GRID_NUM = aegnn::GRID_NUM
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               event_stream_clean,
  input  logic                               node_valid,
  output logic                               node_ready,
  input  grid_idx_t                          node_grid_idx,
  input  logic [L4_OUT_C-1:0][F_WIDTH-1:0]   node_feat_pack,
  output logic                               module_start,
  output grid_idx_t                          grid_idx,
  output logic [L4_OUT_C-1:0][F_WIDTH-1:0]   max_pool_dx_out_pack,
  input  logic                               module_done,
  output logic                               upd_done,
  output logic [1:0]                         dbg_state
);

  localparam int W = L4_OUT_C * F_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_START, ST_WAIT} state_t;

  state_t                             state_q, state_d;
  grid_idx_t                          idx_q;
  logic [L4_OUT_C-1:0][F_WIDTH-1:0]   feat_q;
  logic [GRID_NUM-1:0]                valid_bits;
  logic                               clean_pend;
  logic [W-1:0]                       rd_data;
  logic [L4_OUT_C-1:0][F_WIDTH-1:0]   old_max, new_max, dx;
  logic                               dx_nz;
  logic                               handshake;
  logic                               clean_now;

  // Node handshake: a node transfers on a cycle where node_valid && node_ready;
  // node_ready only rises in IDLE when no clear is due, so a clear always wins.
  assign handshake = node_valid && node_ready;
  assign clean_now = (state_q == ST_IDLE) && (event_stream_clean || clean_pend);
  assign dbg_state = state_q;

  max_pool_mem #(
    .DEPTH (GRID_NUM),
    .WIDTH (W)
  ) u_mem (
    .clk     (clk),
    .rd_en   (handshake),
    .rd_addr (node_grid_idx),
    .rd_data (rd_data),
    .wr_en   (state_q == ST_CMP),
    .wr_addr (idx_q),
    .wr_data (new_max)
  );

  always_comb begin
    old_max = valid_bits[idx_q] ? rd_data : '0;
    new_max = '0;
    dx      = '0;
    for (int c = 0; c < L4_OUT_C; c++) begin
      if (feat_q[c] > old_max[c]) begin
        dx[c]      = feat_q[c] - old_max[c];
        new_max[c] = feat_q[c];
      end else begin
        new_max[c] = old_max[c];
      end
    end
    dx_nz = |dx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (handshake)   state_d = ST_CMP;
      ST_CMP:   state_d = dx_nz ? ST_START : ST_IDLE;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (module_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    node_ready   = (state_q == ST_IDLE) && !event_stream_clean && !clean_pend;
    module_start = (state_q == ST_START);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q                <= '0;
      feat_q               <= '0;
      valid_bits           <= '0;
      clean_pend           <= 1'b0;
      upd_done             <= 1'b0;
      grid_idx             <= '0;
      max_pool_dx_out_pack <= '0;
    end else begin
      if (handshake) begin
        idx_q  <= node_grid_idx;
        feat_q <= node_feat_pack;
      end
      // A clear requested mid-transaction waits for IDLE and then wipes the CMP write too.
      if (clean_now) begin
        valid_bits <= '0;
        clean_pend <= 1'b0;
      end else begin
        if (state_q == ST_CMP) valid_bits[idx_q] <= 1'b1;
        if (event_stream_clean) clean_pend <= 1'b1;
      end
      upd_done <= ((state_q == ST_CMP) && !dx_nz) || ((state_q == ST_WAIT) && module_done);
      if ((state_q == ST_CMP) && dx_nz) begin
        grid_idx             <= idx_q;
        max_pool_dx_out_pack <= dx;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_dx.sv
// Bench for max_pool_dx: reference max model, scoreboard of expected linear
// launches, and latency/handshake checks around each node.
module tb_max_pool_dx;
  import aegnn::grid_idx_t;

  localparam int C = 32;
  localparam int W = C * 8;
  localparam int G = 64;

  typedef logic [C-1:0][7:0] feat_t;

  logic      clk, rstn, event_stream_clean, node_valid, node_ready;
  grid_idx_t node_grid_idx, grid_idx;
  feat_t     node_feat_pack, max_pool_dx_out_pack;
  logic      module_start, module_done, upd_done;
  logic [1:0] dbg_state;

  logic [W+5:0] exp_q[$];
  logic [W+5:0] sb_e;
  int total = 0;
  int bad = 0;
  int  model_max [G][C];
  bit  model_valid [G];

  max_pool_dx dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .event_stream_clean   (event_stream_clean),
    .node_valid           (node_valid),
    .node_ready           (node_ready),
    .node_grid_idx        (node_grid_idx),
    .node_feat_pack       (node_feat_pack),
    .module_start         (module_start),
    .grid_idx             (grid_idx),
    .max_pool_dx_out_pack (max_pool_dx_out_pack),
    .module_done          (module_done),
    .upd_done             (upd_done),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every module_start must match the oldest expected launch
  always @(negedge clk) begin
    if (rstn && module_start) begin
      if (exp_q.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_grid_idx", W'(grid_idx), W'(sb_e[W+5:W]));
        check("sb_dx", max_pool_dx_out_pack, sb_e[W-1:0]);
      end
    end
  end

  task automatic model_clear();
    for (int g = 0; g < G; g++) model_valid[g] = 1'b0;
  endtask

  task automatic model_step(input grid_idx_t idx, input feat_t feat, output feat_t dxv, output bit nz);
    int o, f;
    dxv = '0;
    for (int c = 0; c < C; c++) begin
      o = model_valid[idx] ? model_max[idx][c] : 0;
      f = int'(feat[c]);
      dxv[c] = (f > o) ? 8'(f - o) : 8'd0;
      model_max[idx][c] = (f > o) ? f : o;
    end
    model_valid[idx] = 1'b1;
    nz = (dxv != '0);
  endtask

  // driver: one node, then answer module_start with module_done after done_delay cycles
  task automatic send_node(input grid_idx_t idx, input feat_t feat, input int done_delay, input bit clean_in_wait);
    int n;
    feat_t dxv;
    bit nz;
    n = 0;
    while (!node_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_node", W'(node_ready), 1);
    node_valid     = 1'b1;
    node_grid_idx  = idx;
    node_feat_pack = feat;
    model_step(idx, feat, dxv, nz);
    if (nz) exp_q.push_back({idx, dxv});
    @(posedge clk);
    #1 node_valid = 1'b0;
    @(negedge clk);
    check("cmp_no_start", W'(module_start), 0);
    check("cmp_no_upd", W'(upd_done), 0);
    @(negedge clk);
    if (nz) begin
      check("start_at_t2", W'(module_start), 1);
      for (int i = 0; i < done_delay; i++) begin
        if (i == 1 && clean_in_wait) begin
          event_stream_clean = 1'b1;
          model_clear();
        end
        @(negedge clk);
        event_stream_clean = 1'b0;
      end
      check("wait_no_upd", W'(upd_done), 0);
      check("wait_no_start", W'(module_start), 0);
      module_done = 1'b1;
      @(negedge clk);
      module_done = 1'b0;
      check("upd_after_done", W'(upd_done), 1);
      if (clean_in_wait) begin
        check("clean_pend_blocks", W'(node_ready), 0);
        @(negedge clk);
        check("ready_after_clear", W'(node_ready), 1);
      end else begin
        check("ready_after_done", W'(node_ready), 1);
      end
    end else begin
      check("skip_upd_t2", W'(upd_done), 1);
      check("skip_no_start", W'(module_start), 0);
      check("skip_ready_t2", W'(node_ready), 1);
    end
  endtask

  initial begin
    feat_t f;
    rstn = 1'b0;
    event_stream_clean = 1'b0;
    node_valid = 1'b0;
    node_grid_idx = '0;
    node_feat_pack = '0;
    module_done = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_start", W'(module_start), 0);
    check("rst_upd", W'(upd_done), 0);
    check("rst_grid_idx", W'(grid_idx), 0);
    check("rst_dx", max_pool_dx_out_pack, 0);
    check("rst_state", W'(dbg_state), 0);
    rstn = 1'b1;
    @(negedge clk);

    // directed cases on grid 55
    f = {16{8'd255, 8'd0}};
    send_node(6'd55, f, 3, 1'b0);
    check("t1_dx_const", max_pool_dx_out_pack, f);
    f = {32{8'd1}};
    send_node(6'd55, f, 2, 1'b0);
    f = {32{8'd0}};
    send_node(6'd55, f, 2, 1'b0);
    check("skip_keeps_idx", W'(grid_idx), 55);

    // clean in IDLE, then old max must read as zero
    event_stream_clean = 1'b1;
    model_clear();
    #1 check("clean_blocks_ready", W'(node_ready), 0);
    @(negedge clk);
    event_stream_clean = 1'b0;
    f = {16{8'd0, 8'd255}};
    send_node(6'd55, f, 2, 1'b0);
    check("post_clean_dx_full", max_pool_dx_out_pack, f);

    // clean during WAIT
    send_node(6'd55, {32{8'd200}}, 4, 1'b1);
    f = {32{8'd9}};
    send_node(6'd55, f, 2, 1'b0);
    check("after_wait_clean_dx", max_pool_dx_out_pack, f);

    // random traffic over a few grids, including same-grid back-to-back
    for (int k = 0; k < 24; k++) begin
      for (int c = 0; c < C; c++) f[c] = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      send_node(grid_idx_t'($urandom_range(0, 3) * 21), f, $urandom_range(2, 6), 1'b0);
    end

    // hold: no module_done for 100 cycles while a second node waits
    check("hold_ready_before", W'(node_ready), 1);
    node_valid = 1'b1;
    node_grid_idx = 6'd10;
    node_feat_pack = {32{8'd255}};
    begin
      feat_t dxv;
      bit nz;
      model_step(6'd10, {32{8'd255}}, dxv, nz);
      if (nz) exp_q.push_back({6'd10, dxv});
      else check("hold_setup_nz", 0, 1);
      for (int i = 0; i < 102; i++) begin
        @(negedge clk);
        if (i == 1) check("hold_start", W'(module_start), 1);
        if (i >= 2) begin
          check("hold_no_start", W'(module_start), 0);
          check("hold_ready_low", W'(node_ready), 0);
          check("hold_idx", W'(grid_idx), 10);
          check("hold_dx", max_pool_dx_out_pack, dxv);
        end
      end
    end
    node_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_start", W'(module_start), 0);
    check("midrst_upd", W'(upd_done), 0);
    check("midrst_idx", W'(grid_idx), 0);
    check("midrst_dx", max_pool_dx_out_pack, 0);
    check("midrst_state", W'(dbg_state), 0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    f = {32{8'd3}};
    send_node(6'd10, f, 2, 1'b0);
    check("post_rst_dx", max_pool_dx_out_pack, f);

    repeat (3) @(negedge clk);
    check("sb_drain", W'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
